// File: rtl/mem_wr_ctrl_pkg.sv
// Shared types for the byte-serial store path: store size codes, FSM states
// and the size-to-byte-count decode.
package mem_wr_ctrl_pkg;

    localparam int unsigned MEM_ADDR_BUS = 32;
    localparam int unsigned MEM_BUS      = 32;

    typedef enum logic [1:0] {
        SIZE_B  = 2'b00,
        SIZE_H  = 2'b01,
        SIZE_W  = 2'b10,
        SIZE_WX = 2'b11
    } st_size_e;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } wr_state_e;

    function automatic logic [2:0] size_to_bytes(input logic [1:0] size);
        logic [2:0] n;
        case (size)
            SIZE_B:  n = 3'd1;
            SIZE_H:  n = 3'd2;
            default: n = 3'd4;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/mem_wr_ctrl.sv
// Store-side memory controller: serialises one byte/half/word store onto the
// 8-bit memory bus, least significant byte first, one byte per cycle.
module mem_wr_ctrl
    import mem_wr_ctrl_pkg::*;
#(
    parameter int unsigned ADDR_W = MEM_ADDR_BUS,
    parameter int unsigned DATA_W = MEM_BUS
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              st_valid,
    output logic              st_ready,
    input  logic [ADDR_W-1:0] st_addr,
    input  logic [DATA_W-1:0] st_data,
    input  logic [1:0]        st_size,
    output logic              st_done,
    output logic              mem_ctrl_wr,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_data_o
);

    localparam int unsigned CNT_W = $clog2(DATA_W / 8) + 1;

    wr_state_e         state_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [CNT_W-1:0]  nbytes_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] data_q;
    logic              wr_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [7:0]        mem_data_q;
    logic              done_q;

    logic [ADDR_W-1:0] addr_d;
    logic [7:0]        lane_d;

    always_comb begin
        addr_d = addr_q + ADDR_W'(cnt_q);
        lane_d = data_q[{cnt_q, 3'b000} +: 8];
    end

    // Single-byte stores also pass through SEND, which only emits st_done;
    // this keeps st_ready low during the byte cycle and gives uniform latency.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            nbytes_q   <= '0;
            addr_q     <= '0;
            data_q     <= '0;
            wr_q       <= 1'b0;
            mem_addr_q <= '0;
            mem_data_q <= '0;
            done_q     <= 1'b0;
        end else begin
            wr_q       <= 1'b0;
            mem_addr_q <= '0;
            mem_data_q <= '0;
            done_q     <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (st_valid) begin
                        addr_q     <= st_addr;
                        data_q     <= st_data;
                        nbytes_q   <= CNT_W'(size_to_bytes(st_size));
                        wr_q       <= 1'b1;
                        mem_addr_q <= st_addr;
                        mem_data_q <= st_data[7:0];
                        cnt_q      <= CNT_W'(1);
                        state_q    <= SEND;
                    end
                end
                SEND: begin
                    if (cnt_q == nbytes_q) begin
                        done_q  <= 1'b1;
                        cnt_q   <= '0;
                        state_q <= IDLE;
                    end else begin
                        wr_q       <= 1'b1;
                        mem_addr_q <= addr_d;
                        mem_data_q <= lane_d;
                        cnt_q      <= cnt_q + CNT_W'(1);
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign st_ready    = !rst && (state_q == IDLE);
    assign st_done     = done_q;
    assign mem_ctrl_wr = wr_q;
    assign mem_addr    = mem_addr_q;
    assign mem_data_o  = mem_data_q;

endmodule

// File: tb/tb_mem_wr_ctrl.sv
// Scoreboard bench for mem_wr_ctrl: the driver queues expected bus writes and
// done pulses (cycle-stamped) from a behavioural model; a monitor checks them.
module tb_mem_wr_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        st_valid = 1'b0;
    logic        st_ready;
    logic [31:0] st_addr = '0;
    logic [31:0] st_data = '0;
    logic [1:0]  st_size = '0;
    logic        st_done;
    logic        mem_ctrl_wr;
    logic [31:0] mem_addr;
    logic [7:0]  mem_data_o;

    mem_wr_ctrl #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk(clk), .rst(rst),
        .st_valid(st_valid), .st_ready(st_ready),
        .st_addr(st_addr), .st_data(st_data), .st_size(st_size),
        .st_done(st_done),
        .mem_ctrl_wr(mem_ctrl_wr), .mem_addr(mem_addr), .mem_data_o(mem_data_o)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int unsigned cyc;
        logic [31:0] a;
        logic [7:0]  d;
    } wr_t;

    wr_t         wq[$];
    int unsigned dq[$];
    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        else n_pass++;
    endfunction

    // Reference: a request of N bytes accepted at edge E writes byte i of the
    // data at (addr+i) mod 2^32 in cycle E+i, then st_done in cycle E+N.
    task automatic model_push(input int unsigned e, input logic [31:0] a,
                              input logic [31:0] d, input logic [1:0] sz);
        int unsigned n;
        wr_t w;
        n = (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
        for (int i = 0; i < int'(n); i++) begin
            w.cyc = e + i;
            w.a   = a + i;
            w.d   = 8'((d >> (8 * i)) & 32'hFF);
            wq.push_back(w);
        end
        dq.push_back(e + n);
    endtask

    always @(negedge clk) begin
        if (rst === 1'b0) begin
            if (mem_ctrl_wr) begin
                if (wq.size() == 0) begin
                    chk("unexpected_write", {mem_addr, 24'd0, mem_data_o}, 64'd0);
                end else begin
                    wr_t e;
                    e = wq.pop_front();
                    chk("write_cycle", 64'(cyc), 64'(e.cyc));
                    chk("write_addr", 64'(mem_addr), 64'(e.a));
                    chk("write_data", 64'(mem_data_o), 64'(e.d));
                    chk("ready_while_busy", 64'(st_ready), 64'd0);
                end
            end else begin
                chk("idle_bus_zero", {mem_addr, 24'd0, mem_data_o}, 64'd0);
            end
            if (st_done) begin
                if (dq.size() == 0) begin
                    chk("unexpected_done", 64'd1, 64'd0);
                end else begin
                    chk("done_cycle", 64'(cyc), 64'(dq.pop_front()));
                    chk("ready_in_done", 64'(st_ready), 64'd1);
                end
            end
        end
    end

    task automatic do_store(input logic [31:0] a, input logic [31:0] d,
                            input logic [1:0] sz, input bit chg);
        int unsigned w;
        @(negedge clk);
        st_addr  = a;
        st_data  = d;
        st_size  = sz;
        st_valid = 1'b1;
        w = 0;
        while (!st_ready && w < 50) begin
            @(negedge clk);
            w++;
        end
        if (!st_ready) begin
            chk("ready_timeout", 64'd0, 64'd1);
            st_valid = 1'b0;
            return;
        end
        model_push(cyc + 1, a, d, sz);
        @(posedge clk);
        #1;
        st_valid = 1'b0;
        st_addr  = $urandom;
        st_data  = $urandom;
        st_size  = 2'($urandom);
        if (chg) begin
            repeat (2) begin
                @(negedge clk);
                st_data = $urandom;
                st_addr = $urandom;
            end
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1;
        #12;
        chk("rst_ready", 64'(st_ready), 64'd0);
        chk("rst_wr", 64'(mem_ctrl_wr), 64'd0);
        chk("rst_done", 64'(st_done), 64'd0);
        chk("rst_bus", {mem_addr, 24'd0, mem_data_o}, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("ready_after_rst", 64'(st_ready), 64'd1);

        do_store(32'h0000_0100, 32'hA1B2C3D4, 2'b10, 1'b0);
        repeat (6) @(negedge clk);
        do_store(32'h0000_0007, 32'hFFFFFF5A, 2'b00, 1'b0);
        repeat (4) @(negedge clk);
        do_store(32'h0000_0003, 32'h0000_1234, 2'b01, 1'b0);
        repeat (4) @(negedge clk);
        do_store(32'hFFFF_FFFE, 32'h8877_6655, 2'b10, 1'b0);
        do_store(32'h0000_0040, 32'h0000_00C3, 2'b00, 1'b0);
        repeat (4) @(negedge clk);

        do_store(32'h0000_0200, 32'h1122_3344, 2'b10, 1'b0);
        @(posedge clk);
        #2;
        chk("wr_before_abort", 64'(mem_ctrl_wr), 64'd1);
        #1;
        rst = 1'b1;
        #1;
        chk("abort_wr_drop", 64'(mem_ctrl_wr), 64'd0);
        chk("abort_ready", 64'(st_ready), 64'd0);
        chk("abort_bus", {mem_addr, 24'd0, mem_data_o}, 64'd0);
        wq.delete();
        dq.delete();
        repeat (3) @(negedge clk);
        #2;
        rst = 1'b0;
        @(negedge clk);
        chk("ready_after_abort", 64'(st_ready), 64'd1);
        chk("no_done_after_abort", 64'(st_done), 64'd0);
        do_store(32'h0000_0300, 32'hDEADBEEF, 2'b10, 1'b0);
        repeat (6) @(negedge clk);

        do_store(32'h0000_0400, 32'hCAFE_F00D, 2'b11, 1'b1);
        repeat (6) @(negedge clk);

        for (int k = 0; k < 150; k++) begin
            logic [31:0] a;
            a = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFFC + 32'($urandom_range(0, 3))) : $urandom;
            do_store(a, $urandom, 2'($urandom), 1'($urandom));
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        repeat (10) @(negedge clk);
        chk("writes_drained", 64'(wq.size()), 64'd0);
        chk("dones_drained", 64'(dq.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
